// File: rtl/hyperram_responder_if.sv
// SDR-side HyperRAM link between the host controller and the on-chip responder.
// Signal names follow the responder's point of view (i* = into responder).
interface hyperram_responder_if;
  logic        iCSN;
  logic [15:0] iDQRise;
  logic [15:0] iDQFall;
  logic        iRWDSRise;
  logic        iRWDSFall;
  logic [15:0] oDQRise;
  logic [15:0] oDQFall;
  logic        oDQOE;
  logic        oRWDS;
  logic        oRWDSOE;
  logic        oCmdValid;
  logic [47:0] oCmdCA;

  modport master (
    output iCSN, iDQRise, iDQFall, iRWDSRise, iRWDSFall,
    input  oDQRise, oDQFall, oDQOE, oRWDS, oRWDSOE, oCmdValid, oCmdCA
  );

  modport slave (
    input  iCSN, iDQRise, iDQFall, iRWDSRise, iRWDSFall,
    output oDQRise, oDQFall, oDQOE, oRWDS, oRWDSOE, oCmdValid, oCmdCA
  );
endinterface

// File: rtl/hyperram_responder.sv
// Device-side HyperRAM responder: CA decode, ID/CR register space and a small
// {rise,fall} memory array with fixed initial latency and linear/wrapped bursts.
//
// state | meaning
// IDLE  | waiting for iCSN low; that sample carries CA[47:32]
// CA0   | CA[47:32] held; next sample carries CA[31:16]
// CA1   | next sample carries CA[15:0]; full CA decoded on it
// CA2   | CA complete; next edge pulses oCmdValid and starts latency
// LAT   | initial latency countdown; memory read fetched on terminal count
// RDATA | read data cycles (memory or register)
// WDATA | memory write data cycles
// REGW  | CA complete for a register write; next sample is the CR data
// DONE  | register write taken; ignore everything until iCSN rises
module hyperram_responder #(
  parameter int          AW         = 8,
  parameter int          LATENCY    = 3,
  parameter int          DOUBLE_LAT = 0,
  parameter int          WRAP_LEN   = 16,
  parameter logic [15:0] ID0_VAL    = 16'h0C81,
  parameter logic [15:0] ID1_VAL    = 16'h0001
) (
  input  logic               iClk,
  input  logic               iRst,
  hyperram_responder_if.slave bus
);

  localparam int LAT_CYC = LATENCY * (1 + DOUBLE_LAT);
  localparam int LCW     = (LAT_CYC < 2) ? 1 : $clog2(LAT_CYC);
  localparam logic [AW-1:0] WRAP_MASK = AW'(WRAP_LEN - 1);
  localparam logic [15:0]   CR0_RST   = 16'h8F1F;
  localparam logic [15:0]   CR1_RST   = 16'h0002;

  typedef enum logic [3:0] {
    IDLE, CA0, CA1, CA2, LAT, RDATA, WDATA, REGW, DONE
  } state_t;

  state_t       r_state;
  logic [47:0]  r_ca_buf;
  logic [47:0]  r_cmd_ca;
  logic         r_cmd_valid;
  logic         r_is_rd;
  logic         r_is_reg;
  logic         r_linear;
  logic [1:0]   r_reg_sel;
  logic [AW-1:0] r_addr;
  logic [LCW-1:0] r_lat_cnt;
  logic [15:0]  r_cr0;
  logic [15:0]  r_cr1;
  logic [15:0]  r_dq_rise;
  logic [15:0]  r_dq_fall;
  logic         r_dq_oe;
  logic         r_rwds;
  logic         r_rwds_oe;
  logic [31:0]  r_mem [2**AW];

  logic [47:0]  w_ca_full;
  logic [AW-1:0] w_addr_nxt;
  logic [AW-1:0] w_addr_inc;
  logic [15:0]  w_reg_val;
  logic         w_data_cyc;
  logic         w_mem_we;

  assign w_ca_full  = {r_ca_buf[47:16], bus.iDQRise[7:0], bus.iDQFall[7:0]};
  assign w_addr_inc = r_addr + AW'(1);
  assign w_addr_nxt = r_linear ? w_addr_inc
                               : ((r_addr & ~WRAP_MASK) | (w_addr_inc & WRAP_MASK));
  assign w_data_cyc = !bus.iCSN &&
                      ((r_state == RDATA) || (r_state == WDATA) ||
                       ((r_state == LAT) && (r_lat_cnt == '0)));
  assign w_mem_we   = w_data_cyc && !r_is_rd;

  always_comb begin
    w_reg_val = ID0_VAL;
    case (r_reg_sel)
      2'b00: w_reg_val = ID0_VAL;
      2'b01: w_reg_val = ID1_VAL;
      2'b10: w_reg_val = r_cr0;
      2'b11: w_reg_val = r_cr1;
      default: w_reg_val = ID0_VAL;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state     <= IDLE;
      r_ca_buf    <= '0;
      r_cmd_ca    <= '0;
      r_cmd_valid <= 1'b0;
      r_is_rd     <= 1'b0;
      r_is_reg    <= 1'b0;
      r_linear    <= 1'b0;
      r_reg_sel   <= 2'b00;
      r_addr      <= '0;
      r_lat_cnt   <= '0;
      r_cr0       <= CR0_RST;
      r_cr1       <= CR1_RST;
      r_dq_rise   <= '0;
      r_dq_fall   <= '0;
      r_dq_oe     <= 1'b0;
      r_rwds      <= 1'b0;
      r_rwds_oe   <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      if (bus.iCSN) begin
        r_state   <= IDLE;
        r_dq_oe   <= 1'b0;
        r_rwds    <= 1'b0;
        r_rwds_oe <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_ca_buf[47:32] <= {bus.iDQRise[7:0], bus.iDQFall[7:0]};
            r_rwds_oe       <= 1'b1;
            r_rwds          <= (DOUBLE_LAT != 0);
            r_dq_oe         <= 1'b0;
            r_state         <= CA0;
          end
          CA0: begin
            r_ca_buf[31:16] <= {bus.iDQRise[7:0], bus.iDQFall[7:0]};
            r_state         <= CA1;
          end
          CA1: begin
            r_ca_buf  <= w_ca_full;
            r_is_rd   <= w_ca_full[47];
            r_is_reg  <= w_ca_full[46];
            r_linear  <= w_ca_full[45];
            r_reg_sel <= {w_ca_full[24], w_ca_full[0]};
            r_addr    <= AW'({w_ca_full[44:16], w_ca_full[2:1]});
            r_state   <= (!w_ca_full[47] && w_ca_full[46]) ? REGW : CA2;
          end
          CA2: begin
            r_cmd_valid <= 1'b1;
            r_cmd_ca    <= r_ca_buf;
            r_rwds_oe   <= 1'b0;
            r_rwds      <= 1'b0;
            r_lat_cnt   <= LCW'(LAT_CYC - 1);
            r_state     <= LAT;
          end
          REGW: begin
            r_cmd_valid <= 1'b1;
            r_cmd_ca    <= r_ca_buf;
            r_rwds_oe   <= 1'b0;
            r_rwds      <= 1'b0;
            if (r_reg_sel == 2'b10) r_cr0 <= bus.iDQRise;
            if (r_reg_sel == 2'b11) r_cr1 <= bus.iDQRise;
            r_state     <= DONE;
          end
          LAT: begin
            if (r_lat_cnt == '0) r_state <= r_is_rd ? RDATA : WDATA;
            else                 r_lat_cnt <= r_lat_cnt - LCW'(1);
          end
          default: ;
        endcase
        // First data beat comes straight out of LAT so it is valid exactly at Cd
        if (w_data_cyc) begin
          r_addr <= w_addr_nxt;
          if (r_is_rd) begin
            r_dq_oe   <= 1'b1;
            r_rwds_oe <= 1'b1;
            r_rwds    <= 1'b1;
            if (r_is_reg) begin
              r_dq_rise <= w_reg_val;
              r_dq_fall <= w_reg_val;
            end else begin
              r_dq_rise <= r_mem[r_addr][31:16];
              r_dq_fall <= r_mem[r_addr][15:0];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (w_mem_we) begin
      if (!bus.iRWDSRise) r_mem[r_addr][31:16] <= bus.iDQRise;
      if (!bus.iRWDSFall) r_mem[r_addr][15:0]  <= bus.iDQFall;
    end
  end

  assign bus.oDQRise   = r_dq_rise;
  assign bus.oDQFall   = r_dq_fall;
  assign bus.oDQOE     = r_dq_oe;
  assign bus.oRWDS     = r_rwds;
  assign bus.oRWDSOE   = r_rwds_oe;
  assign bus.oCmdValid = r_cmd_valid;
  assign bus.oCmdCA    = r_cmd_ca;

endmodule

// File: tb/tb_hyperram_responder.sv
// Directed bench for hyperram_responder: one default instance and one with
// double latency, driven cycle by cycle and checked against hand-derived values.
module tb_hyperram_responder;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  hyperram_responder_if if0 ();
  hyperram_responder_if if1 ();

  hyperram_responder dut0 (.iClk(iClk), .iRst(iRst), .bus(if0));
  hyperram_responder #(.DOUBLE_LAT(1)) dut1 (.iClk(iClk), .iRst(iRst), .bus(if1));

  always #5 iClk = ~iClk;

  logic [15:0] wr_rise [64];
  logic [15:0] wr_fall [64];
  logic        wr_mr   [64];
  logic        wr_mf   [64];
  logic        ob_valid  [64];
  logic        ob_oe     [64];
  logic        ob_rwds   [64];
  logic        ob_rwdsoe [64];
  logic [31:0] ob_dq     [64];
  logic [47:0] ob_ca     [64];
  logic        rst_oe;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_wr();
    for (int i = 0; i < 64; i++) begin
      wr_rise[i] = '0; wr_fall[i] = '0; wr_mr[i] = 1'b0; wr_mf[i] = 1'b0;
    end
  endtask

  task automatic drive(input int sel, input logic csn, input logic [15:0] r, input logic [15:0] f,
                       input logic mr, input logic mf);
    if (sel == 0) begin
      if0.iCSN = csn; if0.iDQRise = r; if0.iDQFall = f; if0.iRWDSRise = mr; if0.iRWDSFall = mf;
    end else begin
      if1.iCSN = csn; if1.iDQRise = r; if1.iDQFall = f; if1.iRWDSRise = mr; if1.iRWDSFall = mf;
    end
  endtask

  task automatic sample(input int sel, input int k);
    if (sel == 0) begin
      ob_valid[k] = if0.oCmdValid; ob_oe[k] = if0.oDQOE; ob_rwds[k] = if0.oRWDS;
      ob_rwdsoe[k] = if0.oRWDSOE; ob_dq[k] = {if0.oDQRise, if0.oDQFall}; ob_ca[k] = if0.oCmdCA;
    end else begin
      ob_valid[k] = if1.oCmdValid; ob_oe[k] = if1.oDQOE; ob_rwds[k] = if1.oRWDS;
      ob_rwdsoe[k] = if1.oRWDSOE; ob_dq[k] = {if1.oDQRise, if1.oDQFall}; ob_ca[k] = if1.oCmdCA;
    end
  endtask

  // ob_*[k] holds the outputs registered at edge Ck; three idle samples follow the burst.
  task automatic run_txn(input int sel, input logic [47:0] ca, input int n, input int rst_at);
    int last;
    last = n;
    for (int k = 0; k < n; k++) begin
      @(negedge iClk);
      case (k)
        0: drive(sel, 1'b0, {8'h00, ca[47:40]}, {8'h00, ca[39:32]}, 1'b0, 1'b0);
        1: drive(sel, 1'b0, {8'h00, ca[31:24]}, {8'h00, ca[23:16]}, 1'b0, 1'b0);
        2: drive(sel, 1'b0, {8'h00, ca[15:8]},  {8'h00, ca[7:0]},   1'b0, 1'b0);
        default: drive(sel, 1'b0, wr_rise[k], wr_fall[k], wr_mr[k], wr_mf[k]);
      endcase
      @(posedge iClk); #1;
      sample(sel, k);
      if (k == rst_at) begin
        iRst = 1'b1;
        #1;
        rst_oe = (sel == 0) ? if0.oDQOE : if1.oDQOE;
        @(negedge iClk);
        iRst = 1'b0;
        last = k + 1;
        break;
      end
    end
    for (int k = last; k < last + 3; k++) begin
      @(negedge iClk);
      drive(sel, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
      @(posedge iClk); #1;
      sample(sel, k);
    end
  endtask

  initial begin
    drive(0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    clear_wr();
    rst_oe = 1'b0;
    #12;
    check_val("rst_oe",     {63'd0, if0.oDQOE},     64'd0);
    check_val("rst_rwdsoe", {63'd0, if0.oRWDSOE},   64'd0);
    check_val("rst_valid",  {63'd0, if0.oCmdValid}, 64'd0);
    check_val("rst_ca",     {16'd0, if0.oCmdCA},    64'd0);
    @(negedge iClk);
    iRst = 1'b0;

    // ID0 read: C0..C7 low, data from C6
    run_txn(0, 48'hC0_00_00_00_00_00, 8, -1);
    check_val("id0_ca_rwdsoe", {63'd0, ob_rwdsoe[1]}, 64'd1);
    check_val("id0_ca_rwds",   {63'd0, ob_rwds[1]},   64'd0);
    check_val("id0_valid_c2",  {63'd0, ob_valid[2]},  64'd0);
    check_val("id0_valid_c3",  {63'd0, ob_valid[3]},  64'd1);
    check_val("id0_valid_c4",  {63'd0, ob_valid[4]},  64'd0);
    check_val("id0_ca",        {16'd0, ob_ca[3]},     64'h0000_C000_0000_0000);
    check_val("id0_oe_c5",     {63'd0, ob_oe[5]},     64'd0);
    check_val("id0_oe_c6",     {63'd0, ob_oe[6]},     64'd1);
    check_val("id0_oe_c7",     {63'd0, ob_oe[7]},     64'd1);
    check_val("id0_dq_c6",     {32'd0, ob_dq[6]},     64'h0C81_0C81);
    check_val("id0_dq_c7",     {32'd0, ob_dq[7]},     64'h0C81_0C81);
    check_val("id0_oe_end",    {63'd0, ob_oe[8]},     64'd0);

    // CR0 write (zero latency) then read back
    clear_wr();
    wr_rise[3] = 16'h8F17;
    run_txn(0, 48'h60_00_01_00_00_00, 4, -1);
    check_val("crw_valid", {63'd0, ob_valid[3]}, 64'd1);
    check_val("crw_oe_c3", {63'd0, ob_oe[3]},    64'd0);
    check_val("crw_oe_c4", {63'd0, ob_oe[4]},    64'd0);
    clear_wr();
    run_txn(0, 48'hC0_00_01_00_00_00, 8, -1);
    check_val("cr0_read", {32'd0, ob_dq[6]}, 64'h8F17_8F17);

    // Preload entries 0..15 with a linear write burst
    clear_wr();
    for (int i = 0; i < 16; i++) begin
      wr_rise[6+i] = 16'h1000 + 16'(i);
      wr_fall[6+i] = 16'h2000 + 16'(i);
    end
    run_txn(0, 48'h20_00_00_00_00_00, 22, -1);
    check_val("pre_oe", {63'd0, ob_oe[10]}, 64'd0);

    // Wrapped read of 18 entries from entry 14
    clear_wr();
    run_txn(0, 48'h80_00_00_03_00_04, 24, -1);
    for (int j = 0; j < 18; j++) begin
      int e;
      e = (14 + j) % 16;
      check_val($sformatf("wrap%0d", j), {32'd0, ob_dq[6+j]},
                {32'd0, 16'h1000 + 16'(e), 16'h2000 + 16'(e)});
    end

    // Linear 4-word write at entry 2, low half of word 2 masked
    clear_wr();
    wr_rise[6] = 16'h1111; wr_fall[6] = 16'h2222;
    wr_rise[7] = 16'h3333; wr_fall[7] = 16'h4444;
    wr_rise[8] = 16'h5555; wr_fall[8] = 16'h6666; wr_mf[8] = 1'b1;
    wr_rise[9] = 16'h7777; wr_fall[9] = 16'h8888;
    run_txn(0, 48'h20_00_00_00_00_04, 10, -1);
    clear_wr();
    run_txn(0, 48'hA0_00_00_00_00_04, 10, -1);
    check_val("lin_w0", {32'd0, ob_dq[6]}, 64'h1111_2222);
    check_val("lin_w1", {32'd0, ob_dq[7]}, 64'h3333_4444);
    check_val("lin_w2", {32'd0, ob_dq[8]}, 64'h5555_2004);
    check_val("lin_w3", {32'd0, ob_dq[9]}, 64'h7777_8888);
    check_val("lin_rwds", {63'd0, ob_rwds[7]}, 64'd1);

    // Aborted CA: iCSN high at C1
    run_txn(0, 48'hC0_00_00_00_00_00, 1, -1);
    check_val("abort_v1", {63'd0, ob_valid[1]}, 64'd0);
    check_val("abort_v2", {63'd0, ob_valid[2]}, 64'd0);
    check_val("abort_v3", {63'd0, ob_valid[3]}, 64'd0);
    check_val("abort_ca", {16'd0, ob_ca[3]},    64'h0000_A000_0000_0004);
    check_val("abort_oe", {63'd0, ob_oe[3]},    64'd0);
    check_val("abort_rwdsoe", {63'd0, ob_rwdsoe[2]}, 64'd0);

    // Double latency instance: RWDS high in CA phase, first data at C9
    run_txn(1, 48'hC0_00_00_00_00_00, 11, -1);
    check_val("dl_rwds_c0", {63'd0, ob_rwds[0]}, 64'd1);
    check_val("dl_rwds_c2", {63'd0, ob_rwds[2]}, 64'd1);
    check_val("dl_oe_c8",   {63'd0, ob_oe[8]},   64'd0);
    check_val("dl_oe_c9",   {63'd0, ob_oe[9]},   64'd1);
    check_val("dl_dq_c9",   {32'd0, ob_dq[9]},   64'h0C81_0C81);

    // Async reset during a memory read
    run_txn(0, 48'hA0_00_00_00_00_04, 12, 7);
    check_val("rst_pre_oe", {63'd0, ob_oe[7]}, 64'd1);
    check_val("rst_mid_oe", {63'd0, rst_oe},   64'd0);
    run_txn(0, 48'hC0_00_01_00_00_00, 8, -1);
    check_val("rst_cr0",    {32'd0, ob_dq[6]},    64'h8F1F_8F1F);
    check_val("rst_next_v", {63'd0, ob_valid[3]}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
